mem_bus_resp: RTL
=================

// Module: mem_bus_resp
// PURPOSE
//  Memory-side responder on the Neptune I A bus, the far end of the MAR/PC address path.
//  Holds a single-port synchronous RAM of 2**add_width words of width bits.
//  Serves one read or write per req/ack handshake, with a configurable number of wait states.
//  On reset it sequentially clears every word, which implements the system memory-reset semantics.
// PARAMETERS
//  width       16   data word width (bits)
//  add_width   13   address width; depth = 2**add_width; add_width <= width
//  wait_cycles 2    wait states inserted between request acceptance and access (0..15)
// PORTS
//  clk    in   1          system clock; all logic on posedge
//  rst    in   1          reset, synchronous, active-high; starts full memory clear
//  req    in   1          access request; requester holds it until ack
//  we     in   1          1 = write, 0 = read; sampled with req
//  addr   in   add_width  word address from the A bus (MAR/PC rd port)
//  wdata  in   width      write data; sampled with req
//  rdata  out  width      read data; valid while ack=1, holds until the next read completes
//  ack    out  1          single-cycle completion pulse
//  busy   out  1          1 whenever state != IDLE
// BEHAVIOUR
//  States: CLEAR, IDLE, WAIT, ACCESS, RESP. All outputs are registered or decoded from state.
//  Reset (rst=1 at an edge):
//   - state<=CLEAR, clr_ptr<=0, ack<=0, rdata<=0, cnt<=0; overrides every other input.
//   - Mid-transaction reset aborts the transaction; an unperformed write is discarded.
//  CLEAR:
//   - Each edge: mem[clr_ptr]<=0, clr_ptr<=clr_ptr+1.
//   - After writing address depth-1, state<=IDLE.
//   - Clear lasts exactly depth cycles; busy=1 throughout.
//  IDLE:
//   - If req=1 at edge N: latch addr, we and wdata.
//   - wait_cycles=0: state<=ACCESS. Otherwise cnt<=wait_cycles, state<=WAIT.
//  WAIT:
//   - Each edge cnt<=cnt-1; when cnt==1, state<=ACCESS. WAIT lasts exactly wait_cycles edges.
//  ACCESS (one edge):
//   - Write: mem[a]<=wd. Read: rdata<=mem[a]. In both cases ack<=1, state<=RESP.
//  RESP:
//   - ack=1 for exactly one cycle; next edge ack<=0, state<=IDLE.
//   - req is ignored in RESP, so a still-high req is not re-accepted. The earliest new
//     acceptance is the edge after RESP.
//  Latency: ack rises at edge N+wait_cycles+1 (one rdata/ack cycle).
//  Back-to-back throughput: one access per wait_cycles+3 cycles.
//  req in CLEAR, WAIT, ACCESS or RESP: ignored, not queued.
//   - Dropping req after acceptance does not cancel; the latched transaction completes.
//  Write then read of the same address: the read returns the newly written value.
//  A write leaves rdata unchanged.
//  addr covers the full depth; no out-of-range case exists. cnt and clr_ptr wrap-free by
//  construction.
// TESTING (bench uses width=16, add_width=4, wait_cycles=2 unless stated)
//  1. Reset, then poll -> busy=1 for exactly 16 cycles, then 0; reads of all 16 addresses
//     return 16'h0000.
//  2. Write 16'hBEEF @ 4'h3, then read @ 4'h3 -> each ack rises 3 edges after acceptance and
//     lasts 1 cycle; rdata=16'hBEEF during the read ack.
//  3. Hold req=1 across ack -> exactly one ack per 5 cycles; no double accept in the RESP cycle.
//  4. Accept a write of 16'h1234 @ 4'h7, assert rst during WAIT -> no ack; after the 16-cycle
//     clear, a read @ 4'h7 returns 16'h0000.
//  5. wait_cycles=0: read @ 4'hF after writing 16'hA5A5 -> ack at the edge after acceptance,
//     rdata=16'hA5A5.
//  6. req pulsed for 1 cycle during CLEAR, then dropped -> no ack, no memory change.
//     Pulse in IDLE -> transaction completes.

Source files
------------

// File: rtl/mem_bus_resp.sv
// Memory-side responder for the A bus: single-port RAM with req/ack handshake,
// programmable wait states, and a sequential clear of every word after reset.
module mem_bus_resp #(
    parameter int unsigned width       = 16,
    parameter int unsigned add_width   = 13,
    parameter int unsigned wait_cycles = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [add_width-1:0] addr,
    input  logic [width-1:0]     wdata,
    output logic [width-1:0]     rdata,
    output logic                 ack,
    output logic                 busy
);

    localparam int unsigned DEPTH = 2 ** add_width;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    state_t               state;
    logic [add_width-1:0] clr_ptr;
    logic [add_width-1:0] a_q;
    logic [width-1:0]     wd_q;
    logic                 we_q;
    logic [CNT_W-1:0]     cnt;

    logic [width-1:0]     mem [DEPTH];

    logic                 mem_we;
    logic [add_width-1:0] mem_addr;
    logic [width-1:0]     mem_wd;

    // Single write port shared by the clear sweep and the write access; reset blocks both.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = a_q;
        mem_wd   = wd_q;
        if (!rst) begin
            if (state == CLEAR) begin
                mem_we   = 1'b1;
                mem_addr = clr_ptr;
                mem_wd   = '0;
            end else if (state == ACCESS && we_q) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ack     <= 1'b0;
            rdata   <= '0;
            cnt     <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + add_width'(1);
                    if (clr_ptr == add_width'(DEPTH - 1)) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (req) begin
                        a_q  <= addr;
                        we_q <= we;
                        wd_q <= wdata;
                        if (wait_cycles == 0) begin
                            state <= ACCESS;
                        end else begin
                            cnt   <= CNT_W'(wait_cycles);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata <= mem[a_q];
                    end
                    ack   <= 1'b1;
                    state <= RESP;
                end
                RESP: begin
                    // req is deliberately not sampled here so a held req is not re-accepted
                    state <= IDLE;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
